stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, maximum number of stacked words.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  writes din onto top of stack.
REQ-006 SHALL have port pop  input  1  removes top word and registers it on dout.
REQ-007 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-008 SHALL have port din  input  WIDTH  word to push.
REQ-009 SHALL have port dout  output  WIDTH  last popped word, registered.
REQ-010 SHALL have port empty  output  1  stack holds zero words.
REQ-011 SHALL have port full  output  1  stack holds DEPTH words.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of stored words.
REQ-013 SHALL have port overflow  output  1  sticky, push attempted while full.
REQ-014 SHALL have port underflow  output  1  sticky, pop attempted while empty.

Function
REQ-015 SHALL keep stack pointer sp in range 0..DEPTH, pointing to next free slot; count SHALL equal sp.
REQ-016 SHALL drive empty = (sp==0) and full = (sp==DEPTH) combinationally from sp.
REQ-017 Push only, not full: mem[sp] <= din, sp <= sp+1 on the same clock edge.
REQ-018 Push only, full: memory and sp unchanged; overflow set to 1 on that edge.
REQ-019 Pop only, not empty: dout <= mem[sp-1], sp <= sp-1; data visible on dout in the cycle after the pop cycle (latency 1).
REQ-020 dout SHALL hold its value until the next successful pop or push+pop; push alone SHALL NOT change dout.
REQ-021 Pop only, empty: dout and sp unchanged; underflow set to 1.
REQ-022 Push and pop together, not empty: dout <= mem[sp-1] (old top), mem[sp-1] <= din, sp unchanged; no flag change.
REQ-023 Push and pop together, empty: dout <= din (bypass), sp stays 0, memory unchanged, no flag set.
REQ-024 Push and pop together while full SHALL follow REQ-022 (no overflow).
REQ-025 overflow/underflow SHALL remain 1 until clr_err or reset; clr_err SHALL clear both on the next edge unless a new error occurs in the same cycle, in which case the new error flag SHALL be set (set wins).
REQ-026 Stored memory words SHALL be readable only via pop; no random access.
REQ-027 Push of a word followed by pop SHALL return it unchanged (LIFO order for any sequence up to DEPTH).

Reset
REQ-028 On reset: sp=0, dout=0, overflow=0, underflow=0, hence empty=1, full=0, count=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately and asynchronously; a push/pop in the same cycle SHALL be discarded.
REQ-030 Memory contents SHALL NOT require reset; unread contents after reset are don't-care.

Structure
REQ-031 WIDTH/DEPTH defaults and the count width function SHALL live in the shared CPU package used by the controller and datapath.
REQ-032 Storage SHALL be a sub-module stack_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port at sp-1.
REQ-033 stack_unit SHALL contain sp, dout register, flag logic and push/pop arbitration only.

Verification
REQ-034 Reset, then push 0x11, 0x22, 0x33 -> count=3, empty=0; three pops -> dout 0x33, 0x22, 0x11 each one cycle after pop; empty=1.
REQ-035 Push 16 words 0x00..0x0F -> full=1, count=16; 17th push 0xAA -> overflow=1, count=16; pop -> dout=0x0F.
REQ-036 Pop on empty after reset -> underflow=1, dout=0x00, count=0; clr_err pulse -> underflow=0 next cycle.
REQ-037 With 0x05 on top, push+pop of 0x09 -> dout=0x05, count unchanged; next pop -> dout=0x09.
REQ-038 Empty stack, push+pop of 0x7E -> dout=0x7E, count=0, no flags; clr_err and pop-on-empty in same cycle -> underflow=1.
REQ-039 Assert reset mid-push with count=4 -> count=0, dout=0, flags=0 immediately; subsequent push/pop works normally.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack unit: default geometry, operation decode and
// width helpers used by both the controller and the storage array.
package stack_unit_pkg;

    localparam int unsigned STACK_WIDTH = 8;
    localparam int unsigned STACK_DEPTH = 16;

    // Encoding matches {push, pop} so the request pair casts directly.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpSwap = 2'b11
    } stack_op_e;

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module stack_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack controller: stack pointer, registered pop output, sticky error
// flags and push/pop arbitration around the stack_mem storage array.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int unsigned WIDTH = STACK_WIDTH,
    parameter int unsigned DEPTH = STACK_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clr_err,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic                        full,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned AW = addr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]    r_sp, w_sp_next;
    logic [WIDTH-1:0] r_dout, w_dout_next;
    logic             r_ovf, r_udf;
    logic             w_ovf_set, w_udf_set;
    logic             w_empty, w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr, w_raddr;
    logic [WIDTH-1:0] w_wdata, w_rdata;
    stack_op_e        w_op;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == DEPTH_C);
    assign w_op    = stack_op_e'({push, pop});
    // Read port always points at the current top of stack.
    assign w_raddr = AW'(r_sp - CW'(1));

    always_comb begin
        w_sp_next   = r_sp;
        w_dout_next = r_dout;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        w_we        = 1'b0;
        w_waddr     = AW'(r_sp);
        w_wdata     = din;
        case (w_op)
            OpPush: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we      = 1'b1;
                    w_sp_next = r_sp + CW'(1);
                end
            end
            OpPop: begin
                if (w_empty) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_dout_next = w_rdata;
                    w_sp_next   = r_sp - CW'(1);
                end
            end
            OpSwap: begin
                // Replace the top in place; on an empty stack bypass din to dout.
                if (w_empty) begin
                    w_dout_next = din;
                end else begin
                    w_dout_next = w_rdata;
                    w_we        = 1'b1;
                    w_waddr     = w_raddr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp   <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            r_sp   <= w_sp_next;
            r_dout <= w_dout_next;
            // A fresh error in the clearing cycle wins over clr_err.
            r_ovf  <= (r_ovf & ~clr_err) | w_ovf_set;
            r_udf  <= (r_udf & ~clr_err) | w_udf_set;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign dout      = r_dout;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_sp;
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed and random bench for stack_unit: a queue reference model predicts
// stack state, and a scoreboard holds popped words awaiting comparison on dout.
module tb_stack_unit;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       empty, full, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model[$];
    logic [7:0] sb_q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    always #5 clk = ~clk;

    stack_unit #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .din       (din),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model.delete();
        sb_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(model.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(model.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(model.size() == DEPTH));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_udf"}, 32'(underflow), 32'(m_udf));
    endtask

    // One clock of stimulus; the model is updated and outputs are sampled 1ns after the edge.
    task automatic step(input bit pu, input bit po, input bit ce, input logic [7:0] d);
        logic ovf_set, udf_set;
        logic [7:0] e;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        push = pu; pop = po; clr_err = ce; din = d;
        if (pu && po) begin
            if (model.size() == 0) begin
                sb_q.push_back(d);
            end else begin
                sb_q.push_back(model[$]);
                model[$] = d;
            end
        end else if (pu) begin
            if (model.size() == DEPTH) ovf_set = 1'b1;
            else model.push_back(d);
        end else if (po) begin
            if (model.size() == 0) udf_set = 1'b1;
            else sb_q.push_back(model.pop_back());
        end
        m_ovf = (m_ovf & ~ce) | ovf_set;
        m_udf = (m_udf & ~ce) | udf_set;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            m_dout = e;
            chk("pop_dout", 32'(dout), 32'(e));
        end else begin
            chk("hold_dout", 32'(dout), 32'(m_dout));
        end
        chk_state("st");
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Pop on empty, then clear
        step(0, 1, 0, 8'h00);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_dout", 32'(dout), 32'h00);
        step(0, 0, 1, 8'h00);
        chk("udf_clr", 32'(underflow), 32'd0);

        // Basic LIFO
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        chk("three_count", 32'(count), 32'd3);
        chk("three_dout_hold", 32'(dout), 32'h00);
        step(0, 1, 0, 8'h00);
        chk("pop1", 32'(dout), 32'h33);
        step(0, 1, 0, 8'h00);
        chk("pop2", 32'(dout), 32'h22);
        step(0, 1, 0, 8'h00);
        chk("pop3", 32'(dout), 32'h11);
        chk("drained_empty", 32'(empty), 32'd1);

        // Fill, overflow, pop
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        step(1, 0, 0, 8'hAA);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        step(0, 1, 0, 8'h00);
        chk("after_ovf_pop", 32'(dout), 32'h0F);
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, 8'h00);
        chk("drain_last", 32'(dout), 32'h00);

        // Push+pop with data present
        step(1, 0, 0, 8'h05);
        step(1, 1, 0, 8'h09);
        chk("swap_dout", 32'(dout), 32'h05);
        chk("swap_count", 32'(count), 32'd1);
        step(0, 1, 0, 8'h00);
        chk("swap_then_pop", 32'(dout), 32'h09);

        // Push+pop on empty bypasses; error set wins over clr_err
        step(1, 1, 0, 8'h7E);
        chk("bypass_dout", 32'(dout), 32'h7E);
        chk("bypass_count", 32'(count), 32'd0);
        chk("bypass_udf", 32'(underflow), 32'd0);
        step(0, 1, 1, 8'h00);
        chk("set_wins", 32'(underflow), 32'd1);
        step(0, 0, 1, 8'h00);

        // Push+pop while full must not flag overflow
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h40 + i));
        step(1, 1, 0, 8'h55);
        chk("full_swap_dout", 32'(dout), 32'h4F);
        chk("full_swap_ovf", 32'(overflow), 32'd0);
        step(0, 1, 0, 8'h00);
        chk("full_swap_pop", 32'(dout), 32'h55);

        // Asynchronous reset mid-push
        model_reset();
        #4;
        reset = 1'b1;
        #1;
        chk("rst_fill_count", 32'(count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            step(1, 0, 0, 8'(8'hC0 + i));
        end
        chk("pre_rst_count", 32'(count), 32'd4);
        push = 1'b1; din = 8'hEE;
        #3;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_dout", 32'(dout), 32'h00);
        chk("async_ovf", 32'(overflow), 32'd0);
        chk("async_udf", 32'(underflow), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_push_discard", 32'(count), 32'd0);
        push = 1'b0;
        reset = 1'b0;
        model_reset();
        step(1, 0, 0, 8'h66);
        step(0, 1, 0, 8'h00);
        chk("post_rst_pop", 32'(dout), 32'h66);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
